// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/WRITE control FSM with run/step/halt control, retired count and PC-wrap flag
module cpu_sequencer #(
  parameter int PC_W         = 4,
  parameter int CNT_W        = 8,
  parameter int EXEC_CYCLES  = 1,
  parameter int HALT_ON_WRAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             halt_clr,
  input  logic [PC_W-1:0]  pc_curr,
  input  logic             dec_write_en,
  input  logic             dec_branch,
  input  logic             dec_halt,
  input  logic             alu_eq,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_clear,
  output logic             rf_write_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic             wrapped
);
  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WRITE, HALT} state_e;
  state_e state_q, state_d;
  logic step_q, smode_q, smode_d, wrapped_q, in_wr, wrap, halt_wrap, step_edge;
  logic [EW-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] retired_q;
  assign in_wr = state_q == WRITE;
  assign step_edge = step_req & ~step_q;
  assign ir_load = state_q == FETCH;
  assign pc_load = in_wr & dec_branch & alu_eq;
  assign pc_inc = in_wr & ~(dec_branch & alu_eq);
  assign rf_write_en = in_wr & dec_write_en;
  assign halted = state_q == HALT;
  assign busy = state_q != IDLE && state_q != HALT;
  assign pc_clear = halted & halt_clr;
  assign wrap = pc_inc & (pc_curr == '1);
  assign halt_wrap = (HALT_ON_WRAP != 0) & wrap;
  assign step_ack = in_wr & smode_q & ~halt_wrap;
  assign retired = retired_q;
  assign wrapped = wrapped_q;
  always_comb begin
    state_d = state_q;
    smode_d = smode_q;
    ecnt_d = ecnt_q;
    case (state_q)
      IDLE: if (run || step_edge) begin
        state_d = FETCH;
        smode_d = ~run;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        state_d = dec_halt ? HALT : EXEC;
        ecnt_d = '0;
      end
      EXEC: begin
        state_d = (ecnt_q == EW'(EXEC_CYCLES - 1)) ? WRITE : EXEC;
        ecnt_d = ecnt_q + 1'b1;
      end
      WRITE: begin
        state_d = halt_wrap ? HALT : (!smode_q && run) ? FETCH : IDLE;
        smode_d = 1'b0;
      end
      HALT: state_d = halt_clr ? IDLE : HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smode_q <= 1'b0;
      ecnt_q <= '0;
      step_q <= 1'b0;
      retired_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      smode_q <= smode_d;
      ecnt_q <= ecnt_d;
      step_q <= step_req;
      retired_q <= retired_q + CNT_W'(in_wr);
      wrapped_q <= wrapped_q | wrap;
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector table, wrap/reset sequences and randomized model check for cpu_sequencer
module tb_cpu_sequencer;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, run = 0, step_req = 0, halt_clr = 0;
  logic we = 0, br = 0, eq = 0, dh = 0;
  logic [3:0] pc = 4'd5;
  logic [1:0] ir, inc, ld, clr, rfw, ack, bsy, hlt, wrp;
  logic [7:0] ret [2];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cpu_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .step_ack(ack[0]),
    .halt_clr(halt_clr), .pc_curr(pc), .dec_write_en(we), .dec_branch(br),
    .dec_halt(dh), .alu_eq(eq), .ir_load(ir[0]), .pc_inc(inc[0]), .pc_load(ld[0]),
    .pc_clear(clr[0]), .rf_write_en(rfw[0]), .busy(bsy[0]), .halted(hlt[0]),
    .retired(ret[0]), .wrapped(wrp[0])
  );
  cpu_sequencer #(.HALT_ON_WRAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .step_ack(ack[1]),
    .halt_clr(halt_clr), .pc_curr(pc), .dec_write_en(we), .dec_branch(br),
    .dec_halt(dh), .alu_eq(eq), .ir_load(ir[1]), .pc_inc(inc[1]), .pc_load(ld[1]),
    .pc_clear(clr[1]), .rf_write_en(rfw[1]), .busy(bsy[1]), .halted(hlt[1]),
    .retired(ret[1]), .wrapped(wrp[1])
  );
  typedef struct {
    logic [6:0] in;
    logic [7:0] s;
    logic [7:0] r;
  } vec_t;
  vec_t tbl[$];
  typedef struct {
    int ph;
    bit hlt, sm, sp, wr;
    logic [7:0] rt;
  } mdl_t;
  mdl_t m[2];
  function automatic logic [16:0] got(int k);
    return {ir[k], inc[k], ld[k], clr[k], rfw[k], ack[k], bsy[k], hlt[k], ret[k], wrp[k]};
  endfunction
  task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h (strobes,retired,wrapped) t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic add(logic [6:0] i, logic [7:0] s, logic [7:0] r);
    vec_t v;
    v.in = i;
    v.s = s;
    v.r = r;
    tbl.push_back(v);
  endtask
  function automatic logic [16:0] mexp(int k);
    logic w, tk, inc_, wev;
    w = !m[k].hlt && m[k].ph == W;
    tk = br && eq;
    inc_ = w && !tk;
    wev = inc_ && pc == 4'hF;
    return {!m[k].hlt && m[k].ph == 1, inc_, w && tk, m[k].hlt && halt_clr, w && we,
            w && m[k].sm && !(k == 1 && wev), !m[k].hlt && m[k].ph != 0, m[k].hlt, m[k].rt, m[k].wr};
  endfunction
  task automatic upd(int k);
    bit edge_, wev;
    edge_ = step_req && !m[k].sp;
    m[k].sp = step_req;
    wev = !m[k].hlt && m[k].ph == W && !(br && eq) && pc == 4'hF;
    if (m[k].hlt) begin
      if (halt_clr) m[k].hlt = 0;
    end else if (m[k].ph == 0) begin
      if (run || edge_) begin
        m[k].ph = 1;
        m[k].sm = !run;
      end
    end else if (m[k].ph == 2 && dh) begin
      m[k].hlt = 1;
      m[k].ph = 0;
    end else if (m[k].ph == W) begin
      m[k].rt++;
      m[k].wr |= wev;
      m[k].ph = (k == 1 && wev) ? 0 : (m[k].sm || !run) ? 0 : 1;
      m[k].hlt = k == 1 && wev;
      m[k].sm = 0;
    end else m[k].ph++;
  endtask
  initial begin
    // {run, step, halt_clr, write_en, branch, alu_eq, dec_halt}
    add(7'b000_0000, 8'h00, 0);
    add(7'b100_1000, 8'h00, 0);
    add(7'b100_1000, 8'h82, 0);
    add(7'b100_1000, 8'h02, 0);
    add(7'b100_1000, 8'h02, 0);
    add(7'b100_1000, 8'h4A, 0);
    add(7'b100_1000, 8'h82, 1);
    add(7'b100_1000, 8'h02, 1);
    add(7'b100_1000, 8'h02, 1);
    add(7'b000_1000, 8'h4A, 1);
    add(7'b000_0000, 8'h00, 2);
    add(7'b010_0000, 8'h00, 2);
    add(7'b010_0000, 8'h82, 2);
    add(7'b000_0000, 8'h02, 2);
    add(7'b000_0000, 8'h02, 2);
    add(7'b000_0100, 8'h46, 2);
    add(7'b000_0000, 8'h00, 3);
    add(7'b010_0000, 8'h00, 3);
    add(7'b000_0000, 8'h82, 3);
    add(7'b000_0000, 8'h02, 3);
    add(7'b000_0000, 8'h02, 3);
    add(7'b000_0110, 8'h26, 3);
    add(7'b000_0000, 8'h00, 4);
    add(7'b100_0000, 8'h00, 4);
    add(7'b100_0000, 8'h82, 4);
    add(7'b100_0001, 8'h02, 4);
    add(7'b100_0000, 8'h01, 4);
    add(7'b110_0000, 8'h01, 4);
    add(7'b001_0000, 8'h11, 4);
    add(7'b001_0000, 8'h00, 4);
    add(7'b000_0000, 8'h00, 4);
    add(7'b110_0000, 8'h00, 4);
    add(7'b000_0000, 8'h82, 4);
    add(7'b000_0000, 8'h02, 4);
    add(7'b000_0000, 8'h02, 4);
    add(7'b000_0000, 8'h42, 4);
    add(7'b000_0000, 8'h00, 5);
    #1;
    for (int k = 0; k < 2; k++) chk("reset", got(k), 17'h0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = 1;
      {run, step_req, halt_clr, we, br, eq, dh} = tbl[i].in;
      #1;
      for (int k = 0; k < 2; k++) chk($sformatf("vec%0d.u%0d", i, k), got(k), {tbl[i].s, tbl[i].r, 1'b0});
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    rst_n = 1;
    {run, step_req, halt_clr, we, br, eq, dh} = 7'b100_0000;
    pc = 4'hF;
    repeat (4) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("wrap_write.u%0d", k), got(k), {8'h42, 8'd0, 1'b0});
    @(negedge clk);
    #1;
    chk("wrap_next.u0", got(0), {8'h82, 8'd1, 1'b1});
    chk("wrap_next.u1", got(1), {8'h01, 8'd1, 1'b1});
    we = 1;
    pc = 4'd3;
    repeat (2) @(negedge clk);
    #1;
    chk("exec_before_rst", got(0), {8'h02, 8'd1, 1'b1});
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("rst_mid_exec.u%0d", k), got(k), 17'h0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 2; k++) m[k] = '{0, 0, 0, 0, 0, 8'd0};
    run = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom % 16 == 0) run = ~run;
      step_req = $urandom % 3 == 0;
      halt_clr = $urandom % 6 == 0;
      dh = $urandom % 12 == 0;
      we = 1'($urandom);
      br = 1'($urandom);
      eq = 1'($urandom);
      pc = ($urandom % 3 == 0) ? 4'hF : 4'($urandom);
      #1;
      for (int k = 0; k < 2; k++) chk($sformatf("rand%0d.u%0d", n, k), got(k), mexp(k));
      @(posedge clk);
      for (int k = 0; k < 2; k++) upd(k);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
